// File: rtl/param_seq_core.sv
// Four-phase sequenced ALU core: fetch operands (T=1), execute (T=2), write back (T=3).
// A small general register file is preloadable from the host while the core is idle.
module param_seq_core #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NREGS = 3,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_src_a,
    input  logic [AW-1:0]    cmd_src_b,
    input  logic [AW-1:0]    cmd_dst,
    input  logic             init_we,
    input  logic [AW-1:0]    init_addr,
    input  logic [WIDTH-1:0] init_data,
    output logic [1:0]       T,
    output logic             busy,
    output logic [WIDTH-1:0] outr,
    output logic             done,
    output logic             flag_z,
    output logic             flag_c,
    output logic             err
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StExec  = 2'd2,
        StWrite = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] dr1_q, dr2_q, ac_q, outr_q;
    logic [2:0]       op_q;
    logic [AW-1:0]    src_a_q, src_b_q, dst_q;
    logic             fz_q, fc_q, done_q, err_q;

    logic             accept, cmd_legal, init_ok;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;

    assign cmd_ready = (state_q == StIdle) && E;
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_legal = (32'(cmd_src_a) < NREGS) && (32'(cmd_src_b) < NREGS)
                    && (32'(cmd_dst) < NREGS);
    assign init_ok   = init_we && E && (state_q == StIdle) && (32'(init_addr) < NREGS);

    assign T      = state_q;
    assign busy   = (state_q != StIdle);
    assign outr   = outr_q;
    assign flag_z = fz_q;
    assign flag_c = fc_q;
    // Pulses are masked while stalled so a stall never shows a completion.
    assign done   = done_q && E;
    assign err    = err_q && E;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept && cmd_legal) state_d = StRead;
            StRead:  state_d = StExec;
            StExec:  state_d = StWrite;
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else if (E) begin
            state_q <= state_d;
        end
    end

    assign sum = {1'b0, dr1_q} + {1'b0, dr2_q};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_q)
            3'd0: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            3'd1: begin
                alu_res = dr1_q - dr2_q;
                alu_c   = (dr1_q < dr2_q);
            end
            3'd2: alu_res = dr1_q & dr2_q;
            3'd3: alu_res = dr1_q | dr2_q;
            3'd4: alu_res = dr1_q ^ dr2_q;
            3'd5: begin
                alu_res = {dr1_q[WIDTH-2:0], 1'b0};
                alu_c   = dr1_q[WIDTH-1];
            end
            3'd6: begin
                alu_res = {1'b0, dr1_q[WIDTH-1:1]};
                alu_c   = dr1_q[0];
            end
            default: alu_res = dr1_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
            dr1_q   <= '0;
            dr2_q   <= '0;
            ac_q    <= '0;
            outr_q  <= '0;
            op_q    <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            fz_q    <= 1'b0;
            fc_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (E) begin
                case (state_q)
                    StIdle: begin
                        // Preload lands on the same edge as accept, so T=1 sees it.
                        if (init_ok) regs_q[init_addr] <= init_data;
                        if (accept) begin
                            if (cmd_legal) begin
                                op_q    <= cmd_op;
                                src_a_q <= cmd_src_a;
                                src_b_q <= cmd_src_b;
                                dst_q   <= cmd_dst;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    StRead: begin
                        dr1_q <= regs_q[src_a_q];
                        dr2_q <= regs_q[src_b_q];
                    end
                    StExec: begin
                        ac_q <= alu_res;
                        fz_q <= (alu_res == '0);
                        fc_q <= alu_c;
                    end
                    StWrite: begin
                        regs_q[dst_q] <= ac_q;
                        outr_q        <= ac_q;
                        done_q        <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_param_seq_core.sv
// Randomised and directed bench for param_seq_core against an arithmetic reference model.
module tb_param_seq_core;
    localparam int W = 4;
    localparam int N = 3;
    localparam int A = 2;

    logic         clk = 1'b0;
    logic         rst, E, cmd_valid, cmd_ready, init_we;
    logic [2:0]   cmd_op;
    logic [A-1:0] cmd_src_a, cmd_src_b, cmd_dst, init_addr;
    logic [W-1:0] init_data, outr;
    logic [1:0]   T;
    logic         busy, done, flag_z, flag_c, err;

    int checks = 0;
    int passes = 0;

    int m_r [N];
    int m_outr;
    bit m_z, m_c;

    param_seq_core #(.WIDTH(W), .NREGS(N)) dut (
        .clk(clk), .rst(rst), .E(E), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .T(T), .busy(busy), .outr(outr), .done(done),
        .flag_z(flag_z), .flag_c(flag_c), .err(err)
    );

    always #5 clk = ~clk;

    // Reference: results computed with integer arithmetic then reduced mod 2^W.
    function automatic void model_apply(input int op, input int a, input int b, input int d);
        int x, y, res;
        bit c;
        x = m_r[a];
        y = m_r[b];
        c = 1'b0;
        case (op)
            0: begin res = x + y; c = (res > 15); end
            1: begin res = x - y; c = (x < y); end
            2: res = x & y;
            3: res = x | y;
            4: res = x ^ y;
            5: begin res = x * 2; c = (x >= 8); end
            6: begin res = x / 2; c = (x % 2 == 1); end
            default: res = x;
        endcase
        res    = ((res % 16) + 16) % 16;
        m_r[d] = res;
        m_outr = res;
        m_z    = (res == 0);
        m_c    = c;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) m_r[i] = 0;
        m_outr = 0;
        m_z    = 1'b0;
        m_c    = 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int i, input int v);
        init_we   = 1'b1;
        init_addr = A'(i);
        init_data = W'(v);
        step();
        init_we = 1'b0;
        if (i < N) m_r[i] = v;
    endtask

    // Issues one command; lat = enabled cycles from accept to done, -1 on timeout.
    task automatic do_cmd(input int op, input int a, input int b, input int d, output int lat);
        cmd_op    = 3'(op);
        cmd_src_a = A'(a);
        cmd_src_b = A'(b);
        cmd_dst   = A'(d);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat > 0) model_apply(op, a, b, d);
    endtask

    task automatic read_reg(input int i, output int v);
        int lat;
        do_cmd(7, i, i, i, lat);
        v = (lat > 0) ? int'(outr) : -1;
    endtask

    task automatic test_reset();
        int v;
        rst = 1'b1; E = 1'b1; cmd_valid = 1'b0; init_we = 1'b0;
        cmd_op = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
        init_addr = '0; init_data = '0;
        model_clear();
        #2;
        checks++;
        if ({T, busy, outr, done, err, flag_z, flag_c} !== '0)
            $display("FAIL reset_outputs: got %0h expected 0",
                     {T, busy, outr, done, err, flag_z, flag_c});
        else passes++;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (cmd_ready !== 1'b1 || T !== 2'd0)
            $display("FAIL reset_ready: got ready=%0b T=%0d expected ready=1 T=0", cmd_ready, T);
        else passes++;
        for (int i = 0; i < N; i++) begin
            read_reg(i, v);
            checks++;
            if (v != 0) $display("FAIL reset_reg%0d: got %0d expected 0", i, v);
            else passes++;
        end
    endtask

    task automatic test_directed();
        int lat, v;
        preload(0, 9);
        preload(1, 8);
        do_cmd(0, 0, 1, 2, lat);
        checks++;
        if (lat != 3 || outr !== 4'd1 || flag_c !== 1'b1 || flag_z !== 1'b0)
            $display("FAIL add_9_8: got lat=%0d outr=%0d c=%0b z=%0b expected lat=3 outr=1 c=1 z=0",
                     lat, outr, flag_c, flag_z);
        else passes++;
        read_reg(2, v);
        checks++;
        if (v != 1) $display("FAIL add_writeback: got %0d expected 1", v);
        else passes++;
        do_cmd(1, 1, 1, 0, lat);
        checks++;
        if (outr !== 4'd0 || flag_z !== 1'b1 || flag_c !== 1'b0)
            $display("FAIL sub_self: got outr=%0d z=%0b c=%0b expected 0 1 0", outr, flag_z, flag_c);
        else passes++;
        preload(0, 2);
        preload(1, 5);
        do_cmd(1, 0, 1, 2, lat);
        checks++;
        if (outr !== 4'd13 || flag_c !== 1'b1 || flag_z !== 1'b0)
            $display("FAIL sub_borrow: got outr=%0d c=%0b z=%0b expected 13 1 0", outr, flag_c, flag_z);
        else passes++;
    endtask

    task automatic test_random();
        int lat, op, a, b, d, v;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 0) preload($urandom_range(0, N - 1), $urandom_range(0, 15));
            op = $urandom_range(0, 7);
            a  = $urandom_range(0, N - 1);
            b  = $urandom_range(0, N - 1);
            d  = $urandom_range(0, N - 1);
            do_cmd(op, a, b, d, lat);
            checks++;
            if (lat != 3 || {outr, flag_z, flag_c} !== {W'(m_outr), m_z, m_c})
                $display("FAIL random_op%0d: got lat=%0d outr=%0d z=%0b c=%0b expected lat=3 outr=%0d z=%0b c=%0b",
                         op, lat, outr, flag_z, flag_c, m_outr, m_z, m_c);
            else passes++;
        end
        for (int i = 0; i < N; i++) begin
            d = m_r[i];
            read_reg(i, v);
            checks++;
            if (v != d) $display("FAIL random_reg%0d: got %0d expected %0d", i, v, d);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        int mask, e1, e2, o1, o2;
        preload(0, 6);
        preload(1, 11);
        model_apply(0, 0, 1, 2);
        e1 = m_outr;
        model_apply(4, 2, 0, 1);
        e2 = m_outr;
        cmd_op = 3'd0; cmd_src_a = 2'd0; cmd_src_b = 2'd1; cmd_dst = 2'd2;
        cmd_valid = 1'b1;
        step();
        cmd_op = 3'd4; cmd_src_a = 2'd2; cmd_src_b = 2'd0; cmd_dst = 2'd1;
        mask = 0; o1 = -1; o2 = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 4) cmd_valid = 1'b0;
            if (done === 1'b1) begin
                mask = mask | (1 << i);
                if (i == 3) o1 = int'(outr);
                if (i == 7) o2 = int'(outr);
            end
        end
        checks++;
        if (mask != ((1 << 3) | (1 << 7)))
            $display("FAIL b2b_done_timing: got mask=%0h expected %0h", mask, (1 << 3) | (1 << 7));
        else passes++;
        checks++;
        if (o1 != e1 || o2 != e2)
            $display("FAIL b2b_results: got %0d,%0d expected %0d,%0d", o1, o2, e1, e2);
        else passes++;
    endtask

    task automatic test_stall();
        int lat;
        bit pz, pc;
        preload(0, 3);
        preload(1, 7);
        pz = m_z; pc = m_c;
        cmd_op = 3'd1; cmd_src_a = 2'd0; cmd_src_b = 2'd1; cmd_dst = 2'd2;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        checks++;
        if (T !== 2'd2) $display("FAIL stall_reach_t2: got %0d expected 2", T);
        else passes++;
        E = 1'b0;
        step();
        step();
        checks++;
        if (T !== 2'd2 || done !== 1'b0 || busy !== 1'b1 || flag_z !== pz || flag_c !== pc)
            $display("FAIL stall_hold: got T=%0d done=%0b busy=%0b z=%0b c=%0b expected 2 0 1 %0b %0b",
                     T, done, busy, flag_z, flag_c, pz, pc);
        else passes++;
        E = 1'b1;
        lat = -1;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        model_apply(1, 0, 1, 2);
        checks++;
        if (lat != 2 || outr !== W'(m_outr) || flag_c !== m_c)
            $display("FAIL stall_resume: got lat=%0d outr=%0d c=%0b expected 2 %0d %0b",
                     lat, outr, flag_c, m_outr, m_c);
        else passes++;
        E = 1'b0;
        cmd_valid = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) $display("FAIL stall_ready: got %0b expected 0", cmd_ready);
        else passes++;
        step();
        checks++;
        if (T !== 2'd0 || err !== 1'b0)
            $display("FAIL stall_no_accept: got T=%0d err=%0b expected 0 0", T, err);
        else passes++;
        cmd_valid = 1'b0;
        E = 1'b1;
    endtask

    task automatic test_illegal();
        int v, o;
        bit seen;
        o = int'(outr);
        for (int k = 0; k < 2; k++) begin
            cmd_op = 3'd0;
            cmd_src_a = (k == 0) ? 2'd0 : 2'd3;
            cmd_src_b = 2'd1;
            cmd_dst   = (k == 0) ? 2'd3 : 2'd0;
            cmd_valid = 1'b1;
            step();
            cmd_valid = 1'b0;
            checks++;
            if (err !== 1'b1 || T !== 2'd0)
                $display("FAIL illegal%0d_err: got err=%0b T=%0d expected 1 0", k, err, T);
            else passes++;
            seen = 1'b0;
            step();
            checks++;
            if (err !== 1'b0) $display("FAIL illegal%0d_pulse: got err=%0b expected 0", k, err);
            else passes++;
            for (int i = 0; i < 4; i++) begin
                if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
                step();
            end
            checks++;
            if (seen || outr !== W'(o))
                $display("FAIL illegal%0d_discard: got activity=%0b outr=%0d expected 0 %0d",
                         k, seen, outr, o);
            else passes++;
        end
        for (int i = 0; i < N; i++) begin
            o = m_r[i];
            read_reg(i, v);
            checks++;
            if (v != o) $display("FAIL illegal_reg%0d: got %0d expected %0d", i, v, o);
            else passes++;
        end
    endtask

    task automatic test_init_busy();
        int v, keep;
        keep = m_r[1];
        cmd_op = 3'd7; cmd_src_a = 2'd0; cmd_src_b = 2'd0; cmd_dst = 2'd0;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        init_we = 1'b1; init_addr = 2'd1; init_data = W'(~keep);
        step();
        step();
        step();
        init_we = 1'b0;
        model_apply(7, 0, 0, 0);
        checks++;
        if (done !== 1'b1) $display("FAIL init_busy_done: got %0b expected 1", done);
        else passes++;
        preload(3, 5);
        read_reg(1, v);
        checks++;
        if (v != keep) $display("FAIL init_busy_ignored: got %0d expected %0d", v, keep);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int lat, v;
        bit seen;
        preload(0, 3);
        preload(1, 4);
        cmd_op = 3'd0; cmd_src_a = 2'd0; cmd_src_b = 2'd1; cmd_dst = 2'd2;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        checks++;
        if ({T, busy, outr, done, err, flag_z, flag_c} !== '0)
            $display("FAIL midreset_async: got %0h expected 0", {T, busy, outr, done, err, flag_z, flag_c});
        else passes++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) $display("FAIL midreset_no_done: got activity=1 expected 0");
        else passes++;
        read_reg(2, v);
        checks++;
        if (v != 0) $display("FAIL midreset_dst: got %0d expected 0", v);
        else passes++;
        preload(0, 12);
        preload(1, 1);
        do_cmd(0, 0, 1, 2, lat);
        checks++;
        if (lat != 3 || outr !== W'(m_outr) || flag_c !== m_c)
            $display("FAIL midreset_resume: got lat=%0d outr=%0d c=%0b expected 3 %0d %0b",
                     lat, outr, flag_c, m_outr, m_c);
        else passes++;
    endtask

    task automatic test_same_cycle();
        int lat, v;
        init_we = 1'b1; init_addr = 2'd0; init_data = 4'd7;
        cmd_op = 3'd7; cmd_src_a = 2'd0; cmd_src_b = 2'd2; cmd_dst = 2'd1;
        cmd_valid = 1'b1;
        step();
        init_we = 1'b0;
        cmd_valid = 1'b0;
        m_r[0] = 7;
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        model_apply(7, 0, 2, 1);
        checks++;
        if (lat != 3 || outr !== W'(m_outr))
            $display("FAIL same_cycle_outr: got lat=%0d outr=%0d expected 3 %0d", lat, outr, m_outr);
        else passes++;
        read_reg(1, v);
        checks++;
        if (v != 7) $display("FAIL same_cycle_r1: got %0d expected 7", v);
        else passes++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_init_busy();
        test_reset_mid();
        test_same_cycle();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
